// File: rtl/store_coalesce_queue.sv
// FIFO of vector store ops drained to an AXI write-control port, one burst per run of lanes.
// Build option STORE_COALESCE_EN: when defined, consecutive-address lanes merge into one burst.
module store_coalesce_queue #(
    parameter int LANES     = 8,
    parameter int DEPTH     = 4,
    parameter int DWIDTH    = 32,
    parameter int MAX_BURST = 16
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         st_valid,
    output logic                         st_ready,
    input  logic [LANES*DWIDTH-1:0]      st_addr,
    input  logic [LANES*DWIDTH-1:0]      st_data,
    input  logic [LANES-1:0]             st_mask,
    output logic                         init_write,
    output logic [31:0]                  write_addr,
    output logic [7:0]                   write_len,
    output logic                         w_data_valid,
    output logic [31:0]                  w_data,
    output logic [3:0]                   w_strb,
    input  logic                         w_data_next,
    input  logic                         w_done,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         idle
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int LW = $clog2(LANES);
    localparam int BW = 9;

    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_INIT, S_DATA, S_WAIT} state_t;

    logic [LANES*DWIDTH-1:0] addr_mem [DEPTH];
    logic [LANES*DWIDTH-1:0] data_mem [DEPTH];
    logic [LANES-1:0]        mask_mem [DEPTH];

    state_t           state_q, state_d;
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic [LANES-1:0] wmask_q, wmask_d, run_mask_q, run_mask_d;
    logic [LW-1:0]    cur_lane_q, cur_lane_d;
    logic [BW-1:0]    beats_left_q, beats_left_d;
    logic [31:0]      write_addr_q, write_addr_d;
    logic [7:0]       write_len_q, write_len_d;

    logic             push, pop;
    logic             found, run_open, lane_ok;
    logic [LW-1:0]    lane_lo;
    logic [BW-1:0]    run_len;
    logic [LANES-1:0] run_mask;

    logic [DWIDTH-1:0] head_addr [LANES];
    logic [DWIDTH-1:0] head_data [LANES];

    assign push = st_valid && st_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wptr_q] <= st_addr;
            data_mem[wptr_q] <= st_data;
            mask_mem[wptr_q] <= st_mask;
        end
    end

    // Word-aligned view of the head entry; the byte offset bits never matter.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_head
            assign head_addr[gi] = addr_mem[rptr_q][gi*DWIDTH +: DWIDTH] & ~DWIDTH'(3);
            assign head_data[gi] = data_mem[rptr_q][gi*DWIDTH +: DWIDTH];
        end
    endgenerate

    // Run finder: lowest active lane, then extend while lanes stay active and contiguous.
    always_comb begin
        found    = 1'b0;
        lane_lo  = '0;
        run_len  = BW'(1);
        run_open = 1'b1;
        lane_ok  = 1'b0;
        run_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            if (!found && wmask_q[i]) begin
                found   = 1'b1;
                lane_lo = LW'(i);
            end
        end
        for (int i = 1; i < LANES; i++) begin
            if (i > int'(lane_lo) && run_open) begin
`ifdef STORE_COALESCE_EN
                lane_ok = wmask_q[i] && (head_addr[i] == head_addr[i-1] + DWIDTH'(4))
                          && (int'(run_len) < MAX_BURST);
`else
                lane_ok = 1'b0;
`endif
                if (lane_ok) run_len = run_len + BW'(1);
                else         run_open = 1'b0;
            end
        end
        for (int i = 0; i < LANES; i++) begin
            if (i >= int'(lane_lo) && i < int'(lane_lo) + int'(run_len)) run_mask[i] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        wmask_d      = wmask_q;
        run_mask_d   = run_mask_q;
        cur_lane_d   = cur_lane_q;
        beats_left_d = beats_left_q;
        write_addr_d = write_addr_q;
        write_len_d  = write_len_q;
        pop          = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    state_d = S_SCAN;
                    wmask_d = mask_mem[rptr_q];
                end
            end
            S_SCAN: begin
                if (wmask_q == '0) begin
                    pop     = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    run_mask_d   = run_mask;
                    cur_lane_d   = lane_lo;
                    beats_left_d = run_len;
                    write_addr_d = 32'(head_addr[lane_lo]);
                    write_len_d  = 8'(run_len - BW'(1));
                    state_d      = S_INIT;
                end
            end
            S_INIT: state_d = S_DATA;
            S_DATA: begin
                if (w_data_next) begin
                    if (beats_left_q == BW'(1)) begin
                        state_d = S_WAIT;
                    end else begin
                        cur_lane_d   = cur_lane_q + LW'(1);
                        beats_left_d = beats_left_q - BW'(1);
                    end
                end
            end
            S_WAIT: begin
                if (w_done) begin
                    wmask_d = wmask_q & ~run_mask_q;
                    pop     = ((wmask_q & ~run_mask_q) == '0);
                    state_d = pop ? S_IDLE : S_SCAN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign count_d = count_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            wmask_q      <= '0;
            run_mask_q   <= '0;
            cur_lane_q   <= '0;
            beats_left_q <= '0;
            write_addr_q <= '0;
            write_len_q  <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            wmask_q      <= wmask_d;
            run_mask_q   <= run_mask_d;
            cur_lane_q   <= cur_lane_d;
            beats_left_q <= beats_left_d;
            write_addr_q <= write_addr_d;
            write_len_q  <= write_len_d;
            if (push) wptr_q <= wptr_q + PW'(1);
            if (pop)  rptr_q <= rptr_q + PW'(1);
        end
    end

    assign st_ready     = (count_q != CW'(DEPTH));
    assign count        = count_q;
    assign idle         = (count_q == '0) && (state_q == S_IDLE);
    assign init_write   = (state_q == S_INIT);
    assign w_data_valid = (state_q == S_DATA);
    assign w_data       = (state_q == S_DATA) ? 32'(head_data[cur_lane_q]) : 32'h0;
    assign w_strb       = 4'hF;
    assign write_addr   = write_addr_q;
    assign write_len    = write_len_q;

endmodule

// File: tb/tb_store_coalesce_queue.sv
// Randomised bench for store_coalesce_queue: a burst-list reference model feeds a scoreboard on the AXI side.
module tb_store_coalesce_queue;
    localparam int LANES = 8;
    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int MAXB  = 16;
    localparam int CW    = $clog2(DEPTH+1);

    logic                  clk = 1'b0;
    logic                  rstn = 1'b0;
    logic                  st_valid = 1'b0;
    logic                  st_ready;
    logic [LANES*DW-1:0]   st_addr = '0;
    logic [LANES*DW-1:0]   st_data = '0;
    logic [LANES-1:0]      st_mask = '0;
    logic                  init_write;
    logic [31:0]           write_addr;
    logic [7:0]            write_len;
    logic                  w_data_valid;
    logic [31:0]           w_data;
    logic [3:0]            w_strb;
    logic                  w_data_next = 1'b0;
    logic                  w_done = 1'b0;
    logic [CW-1:0]         count;
    logic                  idle;

    store_coalesce_queue #(.LANES(LANES), .DEPTH(DEPTH), .DWIDTH(DW), .MAX_BURST(MAXB)) dut (
        .clk(clk), .rstn(rstn), .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_data(st_data), .st_mask(st_mask),
        .init_write(init_write), .write_addr(write_addr), .write_len(write_len),
        .w_data_valid(w_data_valid), .w_data(w_data), .w_strb(w_strb),
        .w_data_next(w_data_next), .w_done(w_done), .count(count), .idle(idle)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    logic [31:0] exp_addr [$];
    logic [7:0]  exp_len  [$];
    logic [31:0] exp_data [$];

    int next_mode  = 0;   // 0 always accept, 1 random, 2 never, 3 pattern 1,0,0,1
    int done_delay = 2;
    int spur_en    = 0;
    int init_cnt   = 0;
    int init_seen  = 0;
    int done_req   = 0;
    int done_ack   = 0;
    int beats_left = 0;
    int wait_cnt   = 0;
    int pat_idx    = 0;
    logic        stall_prev = 1'b0;
    logic [31:0] stall_data = '0;

    // Reference: split an op into bursts straight from the lane rules.
    function automatic void model_push(input logic [LANES*DW-1:0] a, input logic [LANES*DW-1:0] d,
                                       input logic [LANES-1:0] m);
        int i;
        i = 0;
        while (i < LANES) begin
            if (!m[i]) begin
                i++;
            end else begin
                int n;
                n = 1;
`ifdef STORE_COALESCE_EN
                while (i + n < LANES && m[i+n] && n < MAXB &&
                       ((a[(i+n)*DW +: DW] & ~32'h3) == (a[(i+n-1)*DW +: DW] & ~32'h3) + 32'd4))
                    n++;
`endif
                exp_addr.push_back(a[i*DW +: DW] & ~32'h3);
                exp_len.push_back(8'(n - 1));
                for (int k = 0; k < n; k++) exp_data.push_back(d[(i+k)*DW +: DW]);
                i += n;
            end
        end
    endfunction

    // Scoreboard on the AXI side, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rstn) begin
            init_cnt   = done_ack;
            done_req   = done_ack;
            beats_left = 0;
            stall_prev = 1'b0;
        end else begin
            if (init_write) begin
                vectors++;
                init_seen++;
                if (init_cnt != done_ack || beats_left != 0 || exp_addr.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_init addr=%h len=%0d outstanding=%0d beats_left=%0d queued=%0d",
                             write_addr, write_len, init_cnt - done_ack, beats_left, exp_addr.size());
                    beats_left = int'(write_len) + 1;
                end else begin
                    logic [31:0] ea;
                    logic [7:0]  el;
                    ea = exp_addr.pop_front();
                    el = exp_len.pop_front();
                    if (write_addr !== ea || write_len !== el) begin
                        errors++;
                        $display("FAIL burst_hdr got addr=%h len=%0d expected addr=%h len=%0d",
                                 write_addr, write_len, ea, el);
                    end
                    beats_left = int'(el) + 1;
                end
                init_cnt++;
            end
            if (w_data_valid && stall_prev) begin
                vectors++;
                if (w_data !== stall_data) begin
                    errors++;
                    $display("FAIL stall_hold got w_data=%h expected %h", w_data, stall_data);
                end
            end
            if (w_data_valid && w_data_next) begin
                vectors++;
                if (beats_left == 0 || exp_data.size() == 0) begin
                    errors++;
                    $display("FAIL extra_beat got w_data=%h expected no beat", w_data);
                end else begin
                    logic [31:0] ed;
                    ed = exp_data.pop_front();
                    if (w_data !== ed || w_strb !== 4'hF) begin
                        errors++;
                        $display("FAIL beat got data=%h strb=%h expected data=%h strb=f", w_data, w_strb, ed);
                    end
                    beats_left--;
                    if (beats_left == 0) done_req++;
                end
            end
            stall_prev = w_data_valid && !w_data_next;
            stall_data = w_data;
        end
    end

    // AXI responder: beat acceptance and write responses.
    always @(posedge clk) begin
        #1;
        if (!rstn) begin
            w_done      = 1'b0;
            w_data_next = 1'b0;
            wait_cnt    = 0;
        end else begin
            case (next_mode)
                0: w_data_next = 1'b1;
                1: w_data_next = 1'($urandom % 2);
                2: w_data_next = 1'b0;
                default: begin
                    w_data_next = (pat_idx == 0 || pat_idx == 3);
                    pat_idx = (pat_idx + 1) % 4;
                end
            endcase
            w_done = 1'b0;
            if (done_req != done_ack) begin
                if (wait_cnt >= done_delay) begin
                    w_done   = 1'b1;
                    done_ack++;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else if (spur_en != 0 && init_cnt == done_ack && ($urandom % 4) == 0) begin
                w_done = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic gen_op(output logic [LANES*DW-1:0] a, output logic [LANES*DW-1:0] d,
                          output logic [LANES-1:0] m);
        logic [31:0] prev;
        prev = $urandom & 32'h0000_FFF0;
        for (int i = 0; i < LANES; i++) begin
            if (i != 0 && ($urandom % 4) == 0) prev = $urandom;
            else if (i != 0) prev = ((prev & ~32'h3) + 32'd4) | ($urandom % 4);
            a[i*DW +: DW] = prev;
            d[i*DW +: DW] = $urandom;
        end
        m = LANES'($urandom);
    endtask

    task automatic push_op(input logic [LANES*DW-1:0] a, input logic [LANES*DW-1:0] d,
                           input logic [LANES-1:0] m);
        int t;
        @(negedge clk);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_mask  = m;
        t = 0;
        while (!st_ready && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (!st_ready) begin
            errors++;
            $display("FAIL push_timeout st_ready=%b expected 1 within 5000 cycles", st_ready);
        end else begin
            model_push(a, d, m);
        end
        @(posedge clk);
        #1 st_valid = 1'b0;
    endtask

    task automatic wait_drain(output bit timed_out);
        int t;
        t = 0;
        timed_out = 1'b0;
        @(negedge clk);
        while (!(idle && exp_addr.size() == 0 && done_req == done_ack) && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20000) timed_out = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset(input string tag);
        #2 rstn = 1'b0;
        #1;
        exp_addr.delete();
        exp_len.delete();
        exp_data.delete();
        vectors++;
        if (count !== '0 || st_ready !== 1'b1 || idle !== 1'b1 || init_write !== 1'b0 ||
            w_data_valid !== 1'b0 || write_addr !== 32'h0 || write_len !== 8'h0 || w_data !== 32'h0) begin
            errors++;
            $display("FAIL %s_reset got count=%0d rdy=%b idle=%b init=%b wv=%b addr=%h len=%0d wd=%h expected 0,1,1,0,0,0,0,0",
                     tag, count, st_ready, idle, init_write, w_data_valid, write_addr, write_len, w_data);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        vectors++;
        if (init_write !== 1'b0 || w_data_valid !== 1'b0 || idle !== 1'b1 || count !== '0) begin
            errors++;
            $display("FAIL %s_post_reset got init=%b wv=%b idle=%b count=%0d expected 0,0,1,0",
                     tag, init_write, w_data_valid, idle, count);
        end
    endtask

    task automatic test_single();
        logic [LANES*DW-1:0] a, d;
        bit to;
        int s;
        for (int i = 0; i < LANES; i++) begin
            a[i*DW +: DW] = 32'h100 + 32'(4*i);
            d[i*DW +: DW] = 32'hA0 + 32'(i);
        end
        next_mode = 0; done_delay = 2; s = init_seen;
        push_op(a, d, 8'hFF);
        @(negedge clk);
        vectors++;
        if (count !== CW'(1)) begin errors++; $display("FAIL single_count1 got %0d expected 1", count); end
        repeat (2) @(negedge clk);
        vectors++;
        if (init_write !== 1'b1) begin errors++; $display("FAIL single_init_latency got %b expected 1", init_write); end
        @(negedge clk);
        vectors++;
        if (w_data_valid !== 1'b1) begin errors++; $display("FAIL single_wv_latency got %b expected 1", w_data_valid); end
        wait_drain(to);
        vectors++;
`ifdef STORE_COALESCE_EN
        if (to || count !== '0 || !idle || init_seen - s != 1) begin
`else
        if (to || count !== '0 || !idle || init_seen - s != 8) begin
`endif
            errors++;
            $display("FAIL single_drain got timeout=%b count=%0d idle=%b bursts=%0d", to, count, idle, init_seen - s);
        end
    endtask

    task automatic test_empty_mask();
        logic [LANES*DW-1:0] a, d;
        logic [LANES-1:0] m;
        int s;
        gen_op(a, d, m);
        s = init_seen;
        push_op(a, d, '0);
        repeat (3) @(negedge clk);
        vectors++;
        if (count !== '0 || idle !== 1'b1 || init_seen != s) begin
            errors++;
            $display("FAIL empty_mask got count=%0d idle=%b inits=%0d expected 0,1,0", count, idle, init_seen - s);
        end
    endtask

    task automatic test_split();
        logic [LANES*DW-1:0] a, d;
        bit to;
        for (int i = 0; i < LANES; i++) begin
            a[i*DW +: DW] = (i < 4) ? 32'h200 + 32'(4*i) : 32'h400 + 32'(4*(i-4));
            d[i*DW +: DW] = $urandom;
        end
        next_mode = 1; done_delay = 1;
        push_op(a, d, 8'hFF);
        for (int i = 0; i < LANES; i++) a[i*DW +: DW] = 32'h800 + 32'(4*i);
        push_op(a, d, 8'b1011_0110);
        wait_drain(to);
        vectors++;
        if (to || count !== '0 || exp_data.size() != 0) begin
            errors++;
            $display("FAIL split_drain got timeout=%b count=%0d left_beats=%0d expected 0,0,0", to, count, exp_data.size());
        end
    endtask

    task automatic test_mask0f();
        logic [LANES*DW-1:0] a, d;
        bit to;
        int s;
        for (int i = 0; i < LANES; i++) begin
            a[i*DW +: DW] = 32'h100 + 32'(4*i);
            d[i*DW +: DW] = $urandom;
        end
        next_mode = 0; s = init_seen;
        push_op(a, d, 8'h0F);
        wait_drain(to);
        vectors++;
`ifdef STORE_COALESCE_EN
        if (to || init_seen - s != 1) begin
`else
        if (to || init_seen - s != 4) begin
`endif
            errors++;
            $display("FAIL mask0f_bursts got timeout=%b bursts=%0d", to, init_seen - s);
        end
    endtask

    task automatic test_full();
        logic [LANES*DW-1:0] a, d;
        logic [LANES-1:0] m;
        bit to;
        next_mode = 2; spur_en = 0;
        for (int k = 0; k < DEPTH; k++) begin
            gen_op(a, d, m);
            push_op(a, d, m | LANES'(1));
        end
        repeat (4) @(negedge clk);
        vectors++;
        if (count !== CW'(DEPTH) || st_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_flag got count=%0d st_ready=%b expected %0d,0", count, st_ready, DEPTH);
        end
        gen_op(a, d, m);
        st_addr = a; st_data = d; st_mask = m; st_valid = 1'b1;
        repeat (4) @(negedge clk);
        st_valid = 1'b0;
        vectors++;
        if (count !== CW'(DEPTH) || st_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_reject got count=%0d st_ready=%b expected %0d,0", count, st_ready, DEPTH);
        end
        next_mode = 1; spur_en = 1; done_delay = 0;
        wait_drain(to);
        vectors++;
        if (to || count !== '0 || exp_data.size() != 0) begin
            errors++;
            $display("FAIL full_drain got timeout=%b count=%0d left_beats=%0d expected 0,0,0", to, count, exp_data.size());
        end
        spur_en = 0;
    endtask

    task automatic test_stall_pattern();
        logic [LANES*DW-1:0] a, d;
        logic [LANES-1:0] m;
        bit to;
        gen_op(a, d, m);
        for (int i = 0; i < LANES; i++) a[i*DW +: DW] = 32'h300 + 32'(4*i);
        next_mode = 3; done_delay = 2;
        push_op(a, d, 8'hFF);
        wait_drain(to);
        vectors++;
        if (to || count !== '0 || exp_data.size() != 0) begin
            errors++;
            $display("FAIL stall_drain got timeout=%b count=%0d left_beats=%0d", to, count, exp_data.size());
        end
    endtask

    task automatic test_reset_mid_data();
        logic [LANES*DW-1:0] a, d;
        logic [LANES-1:0] m;
        int t;
        gen_op(a, d, m);
        next_mode = 2;
        push_op(a, d, 8'hFF);
        t = 0;
        while (!w_data_valid && t < 50) begin @(negedge clk); t++; end
        vectors++;
        if (!w_data_valid) begin
            errors++;
            $display("FAIL mid_reach_data got w_data_valid=%b expected 1", w_data_valid);
        end
        test_reset("mid");
        next_mode = 0;
    endtask

    task automatic test_back_to_back();
        logic [LANES*DW-1:0] a, d;
        logic [LANES-1:0] m;
        bit to;
        next_mode = 1; spur_en = 1;
        for (int k = 0; k < 24; k++) begin
            gen_op(a, d, m);
            done_delay = int'($urandom_range(0, 3));
            push_op(a, d, m);
        end
        wait_drain(to);
        vectors++;
        if (to || count !== '0 || !idle || exp_addr.size() != 0 || exp_data.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain got timeout=%b count=%0d idle=%b left_bursts=%0d left_beats=%0d",
                     to, count, idle, exp_addr.size(), exp_data.size());
        end
        spur_en = 0;
    endtask

    initial begin
        test_reset("init");
        test_single();
        test_empty_mask();
        test_split();
        test_mask0f();
        test_full();
        test_stall_pattern();
        test_reset_mid_data();
        test_single();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/store_coalesce_queue.md
Name: store_coalesce_queue

Overview:
Parametrised successor to the core's single-entry store unit. Buffers up to DEPTH vector store operations, each carrying a per-lane address, per-lane data and a lane mask. Drains them in order to the AXI write-control interface. Runs of active lanes with consecutive word addresses are merged into one burst. Sits between dispatch (FUNC_MEM ops) and the AXI write master; st_ready replaces the old single-store blocking signal.

Parameters:
LANES, 8, threads per vector (lanes per store op)
DEPTH, 4, store entries buffered (power of 2, >=2)
DWIDTH, 32, bits per lane address/data
MAX_BURST, 16, max beats per AXI burst (1..256)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
st_valid  in  1  store op offered
st_ready  out  1  queue can accept (not full)
st_addr  in  LANES*DWIDTH  per-lane byte address, lane 0 in LSBs
st_data  in  LANES*DWIDTH  per-lane store data
st_mask  in  LANES  active-lane mask
init_write  out  1  one-cycle burst start pulse
write_addr  out  32  burst start byte address
write_len  out  8  burst beats minus 1
w_data_valid  out  1  beat valid
w_data  out  32  beat data
w_strb  out  4  byte strobes (always 4'hF)
w_data_next  in  1  beat accepted this cycle
w_done  in  1  burst write response complete
count  out  $clog2(DEPTH+1)  entries occupied
idle  out  1  queue empty and FSM in IDLE

Behaviour:
- Reset (async, rstn low): queue empty, count=0, st_ready=1, idle=1, init_write=0, w_data_valid=0, write_addr=0, write_len=0, w_data=0, FSM=IDLE. Reset mid-burst abandons the burst; no further AXI activity.
- Enqueue: on clk when st_valid&&st_ready. st_ready = (count!=DEPTH); no bypass. Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- Working mask: the head entry keeps a copy of its mask, cleared lane-by-lane as bursts complete.
- Address bits [1:0] are ignored (forced 0); all beats are full words.
- FSM states:
  - IDLE: if count!=0, go to SCAN.
  - SCAN (1 cycle): if working mask==0, pop head and go to IDLE; no AXI traffic. Otherwise pick the lowest active lane L. Extend the run through lanes L+1.. while each lane is active, its address == previous address+4, and run length < MAX_BURST. An inactive lane or an address break ends the run. Latch start lane, beat count n, write_addr=addr[L]. Go to INIT.
  - INIT (1 cycle): init_write=1, write_len=n-1. Go to DATA.
  - DATA: w_data_valid=1, w_data=data of current run lane. Advance on clk when w_data_next=1. w_data holds stable while w_data_next=0. After beat n is accepted, w_data_valid=0 and go to WAIT.
  - WAIT: on w_done, clear the run's lanes from the working mask. If the remaining mask==0, pop head (count-1, simultaneous push honoured), then IDLE; else SCAN.
- w_done arriving outside WAIT is ignored.
- Bursts for an entry issue in ascending lane order; entries drain strictly FIFO. A new burst never starts before the previous w_done.
- Minimum latency: push at cycle 0 → count=1 at 1 → SCAN 2 → init_write 3 → first w_data_valid 4.

Optional Feature:
STORE_COALESCE_EN — defined: runs merge as described, up to MAX_BURST beats. Undefined: every active lane is its own burst with write_len=0 and exactly one beat; the address comparison logic is not built. All other behaviour is identical.

Test Plan:
- Single store, mask 8'hFF, addr[i]=0x100+4i, data[i]=0xA0+i, w_data_next=1, w_done 2 cycles after last beat → one init_write, write_addr=0x100, write_len=7, beats 0xA0..0xA7, then count=0 and idle=1.
- Mask 8'h00 pushed → popped within 3 cycles; init_write never asserted.
- Mask 8'hFF, lanes 0-3 at 0x200+4i and lanes 4-7 at 0x400+4(i-4) → two bursts (0x200,len 3) and (0x400,len 3); mask 8'b10110110 contiguous → bursts at lanes 1-2, 4-5, 7.
- w_data_next=0 and no w_done: push 5 ops → st_ready=0 after 4 accepted, count=4, fifth not taken; then release → all 4 drain in push order.
- Mid-burst w_data_next toggling 1,0,0,1 → w_data stable during stalls, no beat skipped or duplicated; assert rstn=0 mid-DATA → all outputs at reset values, count=0.
- Without STORE_COALESCE_EN, mask 8'h0F contiguous → four bursts, each write_len=0 at 0x100,0x104,0x108,0x10C.
